word_lane_serializer: RTL and testbench
=======================================

// Module: word_lane_serializer
// PURPOSE
//   Parametrised successor to the fixed 16->2x8 half-word split.
//   Accepts one IN_W-bit word over a valid/ready handshake and emits its
//   NUM_LANES = IN_W/LANE_W lanes one per cycle, in MSB-first or LSB-first
//   order, over a second valid/ready handshake.
//   Sits between wide datapath producers and narrow byte/lane consumers.
// PARAMETERS
//   IN_W    16  input word width; must be a multiple of LANE_W
//   LANE_W   8  output lane width; NUM_LANES = IN_W/LANE_W, must be >= 2
//   IDX_W    $clog2(NUM_LANES)  lane index width (localparam, not overridable)
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous, active-high reset
//   in_data    in   IN_W    word to split
//   in_valid   in   1       in_data valid
//   in_ready   out  1       block can accept a word this cycle
//   msb_first  in   1       1: emit in[IN_W-1 -: LANE_W] first; 0: emit in[LANE_W-1:0] first
//   out_data   out  LANE_W  current lane
//   out_valid  out  1       out_data valid
//   out_ready  in   1       consumer accepts out_data this cycle
//   out_idx    out  IDX_W   bit-position index of the current lane (0 = least significant)
//   out_last   out  1       current lane is the final lane of the word
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE; out_valid=0, out_last=0,
//     out_idx=0, out_data=0, in_ready=1; holding register cleared.
//   - FSM: IDLE, SHIFT.
//     IDLE: in_ready=1, out_valid=0. in_valid&&in_ready -> latch in_data and
//       msb_first; set lane counter to 0; -> SHIFT.
//     SHIFT: out_valid=1. Stall while !out_ready (out_data/out_idx/out_last
//       held stable). On out_valid&&out_ready: if not last, counter+1;
//       if last, -> IDLE unless a new word is accepted the same cycle.
//   - in_ready = (state==IDLE) | (out_valid & out_ready & out_last): a new
//     word may be accepted on the cycle its predecessor's last lane drains,
//     giving back-to-back lanes with zero bubbles. The new word's msb_first
//     is sampled with it; changes on msb_first mid-word have no effect.
//   - Latency: first lane valid the cycle after acceptance. Throughput:
//     one word per NUM_LANES cycles when out_ready is held high.
//   - Lane select: counter c; out_idx = msb_first ? NUM_LANES-1-c : c;
//     out_data = word[out_idx*LANE_W +: LANE_W]; out_last = (c==NUM_LANES-1).
//   - in_data ignored when in_ready=0; no data buffered beyond one word.
//   - rst asserted mid-word: current word discarded, no further lanes emitted.
//   - out_valid never drops without a handshake once raised (AXI-stream rule).
//   - Elaboration error ($error in generate) if IN_W % LANE_W != 0 or
//     NUM_LANES < 2.
// STRUCTURE
//   - Shared package lane_pkg: state enum {IDLE, SHIFT} encoding constants,
//     default IN_W/LANE_W values, clog2 helper for non-SV flows.
//   - One natural sub-module: lane_mux (combinational, word + out_idx ->
//     out_data), reused by future deserializer/upsizer blocks.
//   - Datapath: IN_W holding register, IDX_W counter, 1-bit order flag.
// TESTING
//   1 Reset: rst=1 mid-simulation with word in flight -> out_valid=0,
//     in_ready=1 immediately (async), no lane emitted after release.
//   2 Default params, msb_first=1, in=16'hA5C3, out_ready=1 -> A5 (idx1,
//     last0), then C3 (idx0, last1) on consecutive cycles.
//   3 Same word, msb_first=0 -> C3 (idx0) then A5 (idx1,last1).
//   4 Backpressure: out_ready=0 for 3 cycles on first lane -> out_data=A5
//     held stable, in_ready=0, no lane skipped after out_ready=1.
//   5 Back-to-back: words 16'h1234, 16'h5678 with in_valid held, out_ready=1
//     -> 12,34,56,78 on 4 consecutive cycles, in_ready high on lane-34 cycle.
//   6 IN_W=32, LANE_W=8, msb_first=0, in=32'hDEADBEEF -> EF,BE,AD,DE, idx 0..3,
//     out_last only on DE; plus 8 $random words checked against a model.

Source files
------------

// File: rtl/lane_pkg.sv
// Shared types and defaults for the lane serializer family.
package lane_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_IN_W   = 16;
  localparam int DEF_LANE_W = 8;

  // Ceiling log2 for tools without $clog2; returns at least 1 so indices are never zero-width.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    if (res < 1) res = 1;
    return res;
  endfunction

endpackage

// File: rtl/word_lane_serializer_if.sv
// Bundles the word-input and lane-output handshakes of the lane serializer.
interface word_lane_serializer_if #(
  parameter int IN_W   = 16,
  parameter int LANE_W = 8
);
  localparam int NUM_LANES = IN_W / LANE_W;
  localparam int IDX_W     = lane_pkg::clog2(NUM_LANES);

  // Both channels: a transfer occurs on a rising edge where valid && ready;
  // once valid is raised it and its payload stay put until that transfer.
  logic [IN_W-1:0]   in_data;
  logic              in_valid;
  logic              in_ready;
  logic              msb_first;
  logic [LANE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  modport master (
    output in_data, in_valid, msb_first, out_ready,
    input  in_ready, out_data, out_valid, out_idx, out_last
  );

  modport slave (
    input  in_data, in_valid, msb_first, out_ready,
    output in_ready, out_data, out_valid, out_idx, out_last
  );
endinterface

// File: rtl/lane_mux.sv
// Combinational lane picker: returns the LANE_W-bit slice of a word at lane index idx.
module lane_mux #(
  parameter int IN_W   = 16,
  parameter int LANE_W = 8,
  parameter int IDX_W  = 1
) (
  input  logic [IN_W-1:0]   word,
  input  logic [IDX_W-1:0]  idx,
  output logic [LANE_W-1:0] lane
);
  localparam int NUM_LANES = IN_W / LANE_W;

  always_comb begin
    lane = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (idx == IDX_W'(i)) lane = word[i*LANE_W +: LANE_W];
    end
  end
endmodule

// File: rtl/word_lane_serializer.sv
// Splits one IN_W-bit word into IN_W/LANE_W lanes, emitted one per cycle in
// MSB-first or LSB-first order; the next word can be taken as the last lane drains.
module word_lane_serializer
  import lane_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  word_lane_serializer_if.slave  bus,
  output state_t                 dbg_state
);
  localparam int NUM_LANES = IN_W / LANE_W;
  localparam int IDX_W     = clog2(NUM_LANES);

  generate
    if ((IN_W % LANE_W) != 0 || NUM_LANES < 2) begin : g_bad_params
      $error("word_lane_serializer: IN_W must be a multiple of LANE_W with at least 2 lanes");
    end
  endgenerate

  state_t            state, state_nx;
  logic [IN_W-1:0]   word_q;
  logic [IDX_W-1:0]  cnt_q;
  logic              msb_q;
  logic [IDX_W-1:0]  idx;
  logic [LANE_W-1:0] lane;
  logic              last;
  logic              out_valid;
  logic              in_ready;
  logic              accept;
  logic              advance;

  assign last    = (cnt_q == IDX_W'(NUM_LANES - 1));
  assign idx     = msb_q ? (IDX_W'(NUM_LANES - 1) - cnt_q) : cnt_q;
  assign accept  = bus.in_valid && in_ready;
  assign advance = out_valid && bus.out_ready;

  always_comb begin
    state_nx  = state;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nx = SHIFT;
      end
      SHIFT: begin
        out_valid = 1'b1;
        // Draining the last lane frees the holding register in the same cycle.
        if (bus.out_ready && last) begin
          in_ready = 1'b1;
          state_nx = bus.in_valid ? SHIFT : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      word_q <= '0;
      cnt_q  <= '0;
      msb_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        word_q <= bus.in_data;
        msb_q  <= bus.msb_first;
        cnt_q  <= '0;
      end else if (advance && !last) begin
        cnt_q <= cnt_q + IDX_W'(1);
      end
    end
  end

  lane_mux #(
    .IN_W  (IN_W),
    .LANE_W(LANE_W),
    .IDX_W (IDX_W)
  ) u_lane_mux (
    .word(word_q),
    .idx (idx),
    .lane(lane)
  );

  // Outputs read as zero while idle so stale words never appear on the bus.
  assign bus.out_data  = out_valid ? lane : '0;
  assign bus.out_idx   = out_valid ? idx : '0;
  assign bus.out_last  = out_valid && last;
  assign bus.out_valid = out_valid;
  assign bus.in_ready  = in_ready;
  assign dbg_state     = state;
endmodule

// File: tb/tb_word_lane_serializer.sv
// Bench for word_lane_serializer: 16->2x8 and 32->4x8 instances, directed vectors plus random traffic.
module tb_word_lane_serializer;
  import lane_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg16, dbg32;
  int     checks;
  int     errors;
  int     accepted;
  logic [16:0] exp_q[$];

  word_lane_serializer_if #(.IN_W(16), .LANE_W(8)) b16 ();
  word_lane_serializer_if #(.IN_W(32), .LANE_W(8)) b32 ();

  word_lane_serializer #(.IN_W(16), .LANE_W(8)) u16 (.clk(clk), .rst(rst), .bus(b16), .dbg_state(dbg16));
  word_lane_serializer #(.IN_W(32), .LANE_W(8)) u32 (.clk(clk), .rst(rst), .bus(b32), .dbg_state(dbg32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        msb;
    logic        ordy;
    logic        ev;
    logic [7:0]  ed;
    logic        ei;
    logic        el;
    logic        eir;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic iv, input logic [15:0] d, input logic msb, input logic ordy,
                     input logic ev, input logic [7:0] ed, input logic ei, input logic el, input logic eir);
    vec_t v;
    v = '{iv, d, msb, ordy, ev, ed, ei, el, eir};
    vecs.push_back(v);
  endtask

  // One cycle of traffic on either instance, scored against a queue of expected lanes.
  task automatic step(input int which, input logic iv, input logic [31:0] d, input logic msb, input logic ordy);
    logic ov, ir, ol, ev, eir;
    logic [7:0] od, oi;
    logic [16:0] f;
    int n;
    @(negedge clk);
    if (which == 32) begin
      b32.in_valid = iv; b32.in_data = d; b32.msb_first = msb; b32.out_ready = ordy; n = 4;
    end else begin
      b16.in_valid = iv; b16.in_data = d[15:0]; b16.msb_first = msb; b16.out_ready = ordy; n = 2;
    end
    #1;
    if (which == 32) begin
      ov = b32.out_valid; ir = b32.in_ready; ol = b32.out_last; od = b32.out_data; oi = 8'(b32.out_idx);
    end else begin
      ov = b16.out_valid; ir = b16.in_ready; ol = b16.out_last; od = b16.out_data; oi = 8'(b16.out_idx);
    end
    ev  = (exp_q.size() != 0);
    eir = !ev || (exp_q.size() == 1 && ordy);
    check($sformatf("w%0d_out_valid", which), ov, ev);
    check($sformatf("w%0d_in_ready", which), ir, eir);
    if (ev) begin
      f = exp_q[0];
      check($sformatf("w%0d_out_data", which), od, f[7:0]);
      check($sformatf("w%0d_out_idx", which), oi, f[15:8]);
      check($sformatf("w%0d_out_last", which), ol, f[16]);
      if (ordy) void'(exp_q.pop_front());
    end
    if (iv && eir) begin
      accepted++;
      for (int c = 0; c < n; c++) begin
        int lidx;
        lidx = msb ? (n - 1 - c) : c;
        exp_q.push_back({(c == n - 1), 8'(lidx), 8'(d >> (lidx * 8))});
      end
    end
  endtask

  initial begin
    logic [7:0] beef_bytes[4];
    int cyc;
    checks = 0; errors = 0; accepted = 0;
    rst = 1'b1;
    b16.in_valid = 0; b16.in_data = '0; b16.msb_first = 0; b16.out_ready = 0;
    b32.in_valid = 0; b32.in_data = '0; b32.msb_first = 0; b32.out_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", b16.out_valid, 0);
    check("rst_out_last", b16.out_last, 0);
    check("rst_out_idx", b16.out_idx, 0);
    check("rst_out_data", b16.out_data, 0);
    check("rst_in_ready", b16.in_ready, 1);
    check("rst_state", dbg16, IDLE);
    check("rst32_in_ready", b32.in_ready, 1);
    check("rst32_out_valid", b32.out_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    // MSB-first A5C3
    add(1, 16'hA5C3, 1, 1,  0, 8'h00, 0, 0, 1);
    add(0, 16'h0000, 1, 1,  1, 8'hA5, 1, 0, 0);
    add(0, 16'h0000, 1, 1,  1, 8'hC3, 0, 1, 1);
    add(0, 16'h0000, 0, 1,  0, 8'h00, 0, 0, 1);
    // LSB-first A5C3
    add(1, 16'hA5C3, 0, 1,  0, 8'h00, 0, 0, 1);
    add(0, 16'h0000, 0, 1,  1, 8'hC3, 0, 0, 0);
    add(0, 16'h0000, 0, 1,  1, 8'hA5, 1, 1, 1);
    add(0, 16'h0000, 0, 1,  0, 8'h00, 0, 0, 1);
    // Backpressure for 3 cycles on the first lane, msb_first toggled mid-word
    add(1, 16'hA5C3, 1, 0,  0, 8'h00, 0, 0, 1);
    add(0, 16'h0000, 1, 0,  1, 8'hA5, 1, 0, 0);
    add(0, 16'h0000, 0, 0,  1, 8'hA5, 1, 0, 0);
    add(0, 16'h0000, 0, 0,  1, 8'hA5, 1, 0, 0);
    add(0, 16'h0000, 0, 1,  1, 8'hA5, 1, 0, 0);
    add(0, 16'h0000, 0, 1,  1, 8'hC3, 0, 1, 1);
    add(0, 16'h0000, 0, 1,  0, 8'h00, 0, 0, 1);
    // Back-to-back 1234 then 5678
    add(1, 16'h1234, 1, 1,  0, 8'h00, 0, 0, 1);
    add(1, 16'h5678, 1, 1,  1, 8'h12, 1, 0, 0);
    add(1, 16'h5678, 1, 1,  1, 8'h34, 0, 1, 1);
    add(0, 16'h0000, 1, 1,  1, 8'h56, 1, 0, 0);
    add(0, 16'h0000, 1, 1,  1, 8'h78, 0, 1, 1);
    add(0, 16'h0000, 1, 1,  0, 8'h00, 0, 0, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      b16.in_valid = vecs[i].iv; b16.in_data = vecs[i].d;
      b16.msb_first = vecs[i].msb; b16.out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_out_valid", i), b16.out_valid, vecs[i].ev);
      check($sformatf("vec%0d_in_ready", i), b16.in_ready, vecs[i].eir);
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_out_data", i), b16.out_data, vecs[i].ed);
        check($sformatf("vec%0d_out_idx", i), b16.out_idx, vecs[i].ei);
        check($sformatf("vec%0d_out_last", i), b16.out_last, vecs[i].el);
      end
    end

    // Reset with a word in flight: one lane out, the other must never appear.
    step(16, 1, 32'hA5C3, 1, 1);
    step(16, 0, 32'h0, 1, 1);
    @(negedge clk);
    b16.in_valid = 0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", b16.out_valid, 0);
    check("midrst_in_ready", b16.in_ready, 1);
    check("midrst_state", dbg16, IDLE);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) step(16, 0, 32'h0, 0, 1);

    // 32-bit instance, LSB-first DEADBEEF
    beef_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    @(negedge clk);
    b32.in_valid = 1; b32.in_data = 32'hDEADBEEF; b32.msb_first = 0; b32.out_ready = 1;
    #1;
    check("beef_in_ready", b32.in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      b32.in_valid = 0;
      #1;
      check($sformatf("beef%0d_out_valid", k), b32.out_valid, 1);
      check($sformatf("beef%0d_out_data", k), b32.out_data, beef_bytes[k]);
      check($sformatf("beef%0d_out_idx", k), b32.out_idx, k);
      check($sformatf("beef%0d_out_last", k), b32.out_last, (k == 3));
    end
    @(negedge clk);
    #1;
    check("beef_done_out_valid", b32.out_valid, 0);

    // Random words on the 32-bit instance until 8 have been accepted.
    accepted = 0;
    cyc = 0;
    while (accepted < 8 && cyc < 400) begin
      step(32, 1, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      cyc++;
    end
    check("r32_words_accepted", (accepted >= 8), 1);
    repeat (6) step(32, 0, 32'h0, 0, 1);

    // Random traffic on the 16-bit instance.
    for (int r = 0; r < 300; r++)
      step(16, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    repeat (4) step(16, 0, 32'h0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
